// File: rtl/shift_arbiter.sv
// Two-requester arbiter in front of a shared 16-bit logical right barrel shifter,
// followed by a one-entry result register. Define SHIFT_ARB_RR_EN for round-robin ties.
module shift_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        in0_valid,
  output logic        in0_ready,
  input  logic [16:1] in0_a,
  input  logic [4:1]  in0_shift,
  input  logic        in1_valid,
  output logic        in1_ready,
  input  logic [16:1] in1_a,
  input  logic [4:1]  in1_shift,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [16:1] out_data,
  output logic        out_src
);

  // Handshake: a transfer happens on a rising edge where valid && ready; inX_ready is
  // a combinational function of inX_valid, the other valid, out_ready and state only.
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [16:1] data_q, data_d;
  logic        src_q, src_d;
  logic        space;
  logic        tie_grant;
  logic        grant;
  logic        accept;
  logic [16:1] sel_a;
  logic [4:1]  sel_shift;

`ifdef SHIFT_ARB_RR_EN
  logic last_grant_q, last_grant_d;

  always_comb begin
    tie_grant    = ~last_grant_q;
    last_grant_d = accept ? grant : last_grant_q;
  end

  always_ff @(posedge clk) begin
    if (reset) last_grant_q <= 1'b1;
    else       last_grant_q <= last_grant_d;
  end
`else
  always_comb tie_grant = 1'b0;
`endif

  always_comb begin
    space     = (state_q == ST_EMPTY) || out_ready;
    grant     = (in0_valid && in1_valid) ? tie_grant : ~in0_valid;
    in0_ready = !reset && space && in0_valid && !grant;
    in1_ready = !reset && space && in1_valid && grant;
    accept    = in0_ready || in1_ready;
    sel_a     = grant ? in1_a : in0_a;
    sel_shift = grant ? in1_shift : in0_shift;
  end

  // A drain and a new accept on the same edge simply reload the register.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    src_d   = src_q;
    if (accept) begin
      state_d = ST_FULL;
      data_d  = sel_a >> sel_shift;
      src_d   = grant;
    end else if (out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      data_q  <= 16'h0000;
      src_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
    end
  end

  always_comb begin
    out_valid = (state_q == ST_FULL);
    out_data  = data_q;
    out_src   = src_q;
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: directed cases plus random stress against a queue model.
module tb_shift_arbiter;

  logic        clk;
  logic        reset;
  logic        in0_valid, in1_valid;
  logic        in0_ready, in1_ready;
  logic [15:0] in0_a, in1_a;
  logic [3:0]  in0_shift, in1_shift;
  logic        out_valid, out_ready;
  logic [15:0] out_data;
  logic        out_src;

  int checks;
  int errors;

  // Reference model state: {src, data} of accepted operations, oldest first.
  logic [16:0] exp_q[$];
  logic        model_full;
  logic        model_last;
  logic        seq_src[4];

  shift_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in0_a     (in0_a),
    .in0_shift (in0_shift),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .in1_a     (in1_a),
    .in1_shift (in1_shift),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus: drive at negedge, check readies against the model, update model.
  task automatic drive_cycle(input logic rst, input logic v0, input logic [15:0] a0,
                             input logic [3:0] s0, input logic v1, input logic [15:0] a1,
                             input logic [3:0] s1, input logic ordy,
                             output logic acc0, output logic acc1);
    logic space;
    @(negedge clk);
    reset = rst; out_ready = ordy;
    in0_valid = v0; in0_a = a0; in0_shift = s0;
    in1_valid = v1; in1_a = a1; in1_shift = s1;
    #1;
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (rst) begin
      chk("in0_ready_in_reset", 32'(in0_ready), 32'd0);
      chk("in1_ready_in_reset", 32'(in1_ready), 32'd0);
      exp_q.delete();
      model_full = 1'b0;
      model_last = 1'b1;
    end else begin
      chk("out_valid", 32'(out_valid), 32'(model_full));
      space = !model_full || ordy;
      if (space) begin
        if (v0 && v1) begin
`ifdef SHIFT_ARB_RR_EN
          if (model_last) acc0 = 1'b1; else acc1 = 1'b1;
`else
          acc0 = 1'b1;
`endif
        end else begin
          acc0 = v0;
          acc1 = v1;
        end
      end
      chk("in0_ready", 32'(in0_ready), 32'(acc0));
      chk("in1_ready", 32'(in1_ready), 32'(acc1));
      if (acc0) exp_q.push_back({1'b0, a0 >> s0});
      if (acc1) exp_q.push_back({1'b1, a1 >> s1});
      if (acc0 || acc1) begin
        model_full = 1'b1;
        model_last = acc1;
      end else if (ordy) begin
        model_full = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n, input logic ordy);
    logic x0, x1;
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 16'h0, 4'h0, ordy, x0, x1);
  endtask

  // Direct look at the output register just after the next rising edge.
  task automatic expect_out(input string name, input logic v, input logic [15:0] d, input logic s);
    @(posedge clk);
    #1;
    chk({name, "_valid"}, 32'(out_valid), 32'(v));
    chk({name, "_data"}, 32'(out_data), 32'(d));
    chk({name, "_src"}, 32'(out_src), 32'(s));
  endtask

  // Monitor: whenever a result is presented it must match the oldest expected entry.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!reset && out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'(out_valid), 32'd0);
        end else begin
          chk("out_data", 32'(out_data), 32'(exp_q[0][15:0]));
          chk("out_src", 32'(out_src), 32'(exp_q[0][16]));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic        a0_ok, a1_ok;
    logic        v0, v1;
    logic [15:0] a0, a1;
    logic [3:0]  s0, s1;
    logic        ordy;
    checks = 0; errors = 0;
    model_full = 1'b0; model_last = 1'b1;
    reset = 1'b1; out_ready = 1'b0;
    in0_valid = 1'b0; in0_a = '0; in0_shift = '0;
    in1_valid = 1'b0; in1_a = '0; in1_shift = '0;

    drive_cycle(1'b1, 1'b0, 16'h0, 4'h0, 1'b0, 16'h0, 4'h0, 1'b0, a0_ok, a1_ok);
    drive_cycle(1'b1, 1'b0, 16'h0, 4'h0, 1'b0, 16'h0, 4'h0, 1'b0, a0_ok, a1_ok);
    expect_out("reset", 1'b0, 16'h0000, 1'b0);

    // Basic shifts, including shift 15 and shift 0.
    drive_cycle(1'b0, 1'b1, 16'h8001, 4'd1, 1'b0, 16'h0, 4'h0, 1'b1, a0_ok, a1_ok);
    chk("first_accept", 32'(a0_ok), 32'd1);
    expect_out("op_8001_s1", 1'b1, 16'h4000, 1'b0);
    drive_cycle(1'b0, 1'b0, 16'h0, 4'h0, 1'b1, 16'h8000, 4'd15, 1'b1, a0_ok, a1_ok);
    expect_out("op_8000_s15", 1'b1, 16'h0001, 1'b1);
    drive_cycle(1'b0, 1'b1, 16'hA5A5, 4'd0, 1'b0, 16'h0, 4'h0, 1'b1, a0_ok, a1_ok);
    expect_out("op_a5a5_s0", 1'b1, 16'hA5A5, 1'b0);
    idle(2, 1'b1);

    // Tie sequence right after reset.
    drive_cycle(1'b1, 1'b0, 16'h0, 4'h0, 1'b0, 16'h0, 4'h0, 1'b1, a0_ok, a1_ok);
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b0, 1'b1, 16'h1234, 4'd2, 1'b1, 16'hF0F0, 4'd4, 1'b1, a0_ok, a1_ok);
      seq_src[i] = in1_ready;
    end
    for (int i = 0; i < 4; i++) begin
`ifdef SHIFT_ARB_RR_EN
      chk("tie_sequence", 32'(seq_src[i]), 32'(i % 2));
`else
      chk("tie_sequence", 32'(seq_src[i]), 32'd0);
`endif
    end
    idle(2, 1'b1);

    // Back-pressure: hold three cycles with both valid, then release.
    drive_cycle(1'b0, 1'b1, 16'hBEEF, 4'd3, 1'b0, 16'h0, 4'h0, 1'b1, a0_ok, a1_ok);
    for (int i = 0; i < 3; i++)
      drive_cycle(1'b0, 1'b1, 16'h1111, 4'd1, 1'b1, 16'h2222, 4'd2, 1'b0, a0_ok, a1_ok);
    for (int i = 0; i < 3; i++)
      drive_cycle(1'b0, 1'b1, 16'h1111, 4'd1, 1'b1, 16'h2222, 4'd2, 1'b1, a0_ok, a1_ok);
    idle(2, 1'b1);

    // Reset while a result is held and in0 is requesting.
    drive_cycle(1'b0, 1'b1, 16'hFFFF, 4'd4, 1'b0, 16'h0, 4'h0, 1'b0, a0_ok, a1_ok);
    drive_cycle(1'b1, 1'b1, 16'hFFFF, 4'd4, 1'b0, 16'h0, 4'h0, 1'b0, a0_ok, a1_ok);
    expect_out("mid_reset", 1'b0, 16'h0000, 1'b0);

    // Random stress; a requester keeps its operation until it is accepted.
    v0 = 1'b0; v1 = 1'b0; a0 = '0; a1 = '0; s0 = '0; s1 = '0;
    for (int i = 0; i < 2000; i++) begin
      if (!v0 && $urandom_range(0, 2) != 0) begin
        v0 = 1'b1; a0 = 16'($urandom); s0 = 4'($urandom_range(0, 15));
      end
      if (!v1 && $urandom_range(0, 2) != 0) begin
        v1 = 1'b1; a1 = 16'($urandom); s1 = 4'($urandom_range(0, 15));
      end
      ordy = ($urandom_range(0, 3) != 0);
      drive_cycle(1'b0, v0, a0, s0, v1, a1, s1, ordy, a0_ok, a1_ok);
      if (a0_ok) v0 = 1'b0;
      if (a1_ok) v1 = 1'b0;
    end
    idle(4, 1'b1);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 Parameters: none; datapath width fixed at 16 bits, shift amount fixed at 4 bits, all buses indexed [N:1] with bit 1 = LSB.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in0_valid  input  1  requester 0 presents an operation.
REQ-005 in0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 in0_a  input  16  requester 0 operand, [16:1].
REQ-007 in0_shift  input  4  requester 0 right-shift amount, [4:1].
REQ-008 in1_valid  input  1  requester 1 presents an operation.
REQ-009 in1_ready  output  1  requester 1 operation accepted this cycle.
REQ-010 in1_a  input  16  requester 1 operand, [16:1].
REQ-011 in1_shift  input  4  requester 1 right-shift amount, [4:1].
REQ-012 out_valid  output  1  result register holds a valid result.
REQ-013 out_ready  input  1  consumer takes the result this cycle.
REQ-014 out_data  output  16  shifted result, [16:1].
REQ-015 out_src  output  1  originating requester of out_data (0 or 1).

Function
REQ-016 The block SHALL share one 16-bit logical right barrel shift datapath between the two requesters, with a one-entry registered result stage.
REQ-017 Result stage has two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-018 space = !out_valid || out_ready; an operation SHALL be accepted only when space=1.
REQ-019 At most one of in0_ready/in1_ready SHALL be high per cycle; inX_ready = space && grant==X && inX_valid.
REQ-020 in*_ready MAY depend combinationally on in*_valid and out_ready; in*_valid SHALL NOT depend on in*_ready.
REQ-021 Single valid requester SHALL be granted whenever space=1.
REQ-022 Both valid: grant per arbitration policy (REQ-033/034); last_grant register updates only on an accepted transfer.
REQ-023 Accept at edge N: out_data = inX_a >> inX_shift (logical, zero-filled from bit 16), out_src = X, out_valid = 1 after edge N; latency 1 cycle.
REQ-024 Shift 0 SHALL pass operand unchanged; shift 15 SHALL yield out_data[1] = a[16], out_data[16:2] = 0.
REQ-025 FULL and out_ready=1 with a new accept: register reloads in same edge, out_valid stays 1 (full throughput, one result per cycle).
REQ-026 FULL and out_ready=1 with no accept: out_valid SHALL go 0 next cycle.
REQ-027 FULL and out_ready=0: out_data, out_src, out_valid SHALL hold stable; both in*_ready SHALL be 0.
REQ-028 No request SHALL be dropped or duplicated; a requester holding valid SHALL be served within 2 accepts (round-robin build).

Reset
REQ-029 reset=1 at a rising edge SHALL set out_valid=0, out_data=16'h0000, out_src=0, last_grant=1.
REQ-030 While reset=1, in0_ready and in1_ready SHALL be 0 (reset dominates all handshakes).
REQ-031 Reset mid-operation SHALL discard any held result; first post-reset cycle behaves as EMPTY.
REQ-032 Reset SHALL take precedence over any simultaneous accept or drain.

Configuration
REQ-033 With SHIFT_ARB_RR_EN defined: round-robin; on tie grant the requester != last_grant; after reset requester 0 wins first tie.
REQ-034 Without SHIFT_ARB_RR_EN: fixed priority, requester 0 always wins a tie; last_grant register SHALL be omitted; REQ-028 starvation bound not applicable.

Verification
REQ-035 Reset, then in0_valid=1, in0_a=16'h8001, in0_shift=4'd1, out_ready=1 -> in0_ready=1 same cycle; next cycle out_valid=1, out_data=16'h4000, out_src=0.
REQ-036 in1 only, in1_a=16'h8000, in1_shift=4'd15 -> out_data=16'h0001, out_src=1; shift 0 with 16'hA5A5 -> 16'hA5A5.
REQ-037 Both valid continuously, out_ready=1, RR build -> out_src sequence 0,1,0,1 on consecutive cycles; fixed-priority build -> 0,0,0,0.
REQ-038 Result held with out_ready=0 for 3 cycles while both valid -> both ready=0, out_data/out_src stable; raise out_ready -> back-to-back accept, out_valid stays 1.
REQ-039 reset asserted one cycle while out_valid=1 and in0_valid=1 -> next cycle out_valid=0, out_data=16'h0000, in0_ready=0 during reset.
REQ-040 Random valid/ready stress against a reference queue model -> every accepted operation appears exactly once, in order, with correct out_data and out_src.
